// File: rtl/ram_burst_reader.sv
// Burst read sequencer for an asynchronous-read register-file RAM.
// Streams burst_len consecutive words from base_addr onto a valid/ready output with backpressure.
module ram_burst_reader #(
  parameter int unsigned data_width = 16,
  parameter int unsigned addr_width = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width:0]   burst_len,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] ram_rd_addr,
  input  logic [data_width-1:0] ram_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out_data,
  output logic                  out_last
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e              state_q;
  logic [addr_width:0] remaining_q;
  logic                loadable;
  logic                last_word;

  // Output register can take a new word when empty or being drained this cycle.
  assign loadable  = !out_valid || out_ready;
  assign last_word = (remaining_q == (addr_width + 1)'(1));

  // ram_rd_addr doubles as the read pointer; it wraps naturally at the top address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ram_rd_addr <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state_q   <= StIdle;
        busy      <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              if (burst_len != '0) begin
                state_q     <= StRead;
                busy        <= 1'b1;
                ram_rd_addr <= base_addr;
                remaining_q <= burst_len;
              end else begin
                done <= 1'b1;
              end
            end
          end
          StRead: begin
            if (loadable) begin
              out_data    <= ram_rd_data;
              out_valid   <= 1'b1;
              out_last    <= last_word;
              ram_rd_addr <= ram_rd_addr + addr_width'(1);
              remaining_q <= remaining_q - (addr_width + 1)'(1);
              if (last_word) state_q <= StDrain;
            end
          end
          StDrain: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state_q   <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Read-side sequencer for the asynchronous-read register-file RAM used for block buffering in the decoder.
- On a start command, reads a burst of consecutive words beginning at a base address. Drives the RAM read address and captures the combinational read data in the same cycle.
- Presents the words on a valid/ready stream with full backpressure, and signals completion with a one-cycle done pulse.
- Sits between per-block RAM buffers and downstream consumers such as the reconstruction and deblocking datapaths.

Parameters:
- data_width, 16: width of a RAM word and of out_data (1..128).
- addr_width, 4: RAM address width. Addressable depth is 2^addr_width (1..8).

Ports:
- clk, input, 1: clock; everything is on its rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- start, input, 1: burst request. Sampled only in IDLE.
- abort, input, 1: synchronous flush to IDLE. Sampled in any state.
- base_addr, input, addr_width: first word address. Sampled with start.
- burst_len, input, addr_width+1: number of words, 0..2^addr_width. Sampled with start.
- busy, output, 1: high while a burst is in progress.
- done, output, 1: one-cycle pulse when a burst completes normally.
- ram_rd_addr, output, addr_width: address driven to the RAM asynchronous read port.
- ram_rd_data, input, data_width: RAM read data, combinational from ram_rd_addr.
- out_valid, output, 1: out_data holds a valid word.
- out_ready, input, 1: consumer accepts the word in this cycle.
- out_data, output, data_width: registered output word.
- out_last, output, 1: qualifies the final word of the burst; meaningful only while out_valid=1.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low. When rst_n=0 at a rising edge, the block returns to IDLE with all outputs at 0: busy=0, done=0, ram_rd_addr=0, out_valid=0, out_data=0, out_last=0. This also applies if reset arrives mid-burst.
- States:
  - IDLE: busy=0, ram_rd_addr holds its last value.
  - READ: busy=1, words are being issued.
  - DRAIN: busy=1, all words issued, waiting for the last word to be accepted.
- IDLE -> READ: start=1 and burst_len!=0. Capture rd_ptr=base_addr and remaining=burst_len. ram_rd_addr=base_addr in the first READ cycle.
- IDLE with start=1 and burst_len=0: stay in IDLE, pulse done on the next cycle, emit no words.
- Transfer rule: a word is accepted when out_valid & out_ready. The output register is loadable when it is empty, or when it is full and being accepted in this cycle.
- In READ, when the output register is loadable:
  - out_data <= ram_rd_data, out_valid <= 1, out_last <= (remaining==1).
  - rd_ptr increments, remaining decrements.
  - If remaining==1, go to DRAIN. Otherwise stay in READ.
- Address arithmetic: rd_ptr increments modulo 2^addr_width, so base_addr + burst_len may wrap past the top address to 0.
- Throughput: one word per cycle while out_ready=1 is held. First out_valid occurs 2 cycles after the start edge.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and ram_rd_addr hold stable.
- DRAIN: when the last word is accepted, out_valid <= 0 and the state goes to IDLE. done=1 for exactly the following cycle, with busy=0 in that cycle.
- start while busy=1 is ignored. start in the same cycle as the done pulse is accepted, since the state is IDLE.
- abort=1 in any state: next cycle state is IDLE and out_valid=0, with no done pulse. abort takes priority over start and over a concurrent output transfer.
- out_data and out_last keep their last values when out_valid=0.

Test Plan:
- Basic burst: RAM preloaded with mem[i]=0x100+i. Issue start with base=2, len=4, out_ready held 1. Expect words 0x102..0x105 on 4 consecutive cycles, first one 2 cycles after start. out_last=1 only on 0x105. done pulses 1 cycle after the 0x105 transfer.
- Wrap-around: base=14, len=4, addr_width=4. Expect ram_rd_addr sequence 14, 15, 0, 1 and data 0x10E, 0x10F, 0x100, 0x101.
- Backpressure: len=3, out_ready toggled 1,0,0,1,0,1. Each word is held stable while stalled, no word is duplicated or dropped, and done pulses exactly once.
- Edge lengths:
  - len=0: done pulses the next cycle, out_valid never rises.
  - len=16 from base=5: all 16 words are emitted and the last one is from address 4.
  - start pulsed mid-burst: ignored.
- Abort and reset mid-burst:
  - abort=1 during the 2nd word with out_ready=0: next cycle out_valid=0, busy=0, no done pulse. A new start then runs cleanly.
  - rst_n=0 for one edge mid-burst: all outputs are 0 on the following cycle.
- Back-to-back bursts: assert start in the same cycle as done. The second burst's first word appears 2 cycles later with correct data.
